// File: rtl/case_4_sdiv_pkg.sv
// ---------------------------------------------------------------------------
// case_4_sdiv_pkg
// Shared widths, iteration count and FSM state type for the sequential
// 13s / 10s signed divider (case_4_sdiv_13s_10s_13_seq_1).
// ---------------------------------------------------------------------------
package case_4_sdiv_pkg;

   localparam int DIVIDEND_W = 13;
   localparam int DIVISOR_W  = 10;
   localparam int QUOT_W     = 13;
   localparam int REM_W      = 10;
   localparam int ITER       = 13;
   localparam int CNT_W      = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } sdiv_state_t;

endpackage

// File: rtl/case_4_sdiv_13s_10s_13_seq_1_step.sv
// ---------------------------------------------------------------------------
// case_4_sdiv_13s_10s_13_seq_1_step
// One radix-2 restoring division step (combinational).
//   i_rem  : 11-bit partial remainder
//   i_bit  : next dividend bit (MSB first)
//   i_dsr  : |divisor|, 10-bit unsigned
//   o_rem  : next partial remainder
//   o_qbit : quotient bit produced by this step
// ---------------------------------------------------------------------------
module case_4_sdiv_13s_10s_13_seq_1_step
   import case_4_sdiv_pkg::*;
(
   input  logic [REM_W:0]       i_rem,
   input  logic                 i_bit,
   input  logic [DIVISOR_W-1:0] i_dsr,
   output logic [REM_W:0]       o_rem,
   output logic                 o_qbit
);

   logic [REM_W:0]   w_shift;
   logic [REM_W+1:0] w_diff;
   logic             w_unused;

   // The partial remainder stays below |divisor| <= 512, so its MSB is
   // always zero before the shift and drops out of the 11-bit compare.
   assign w_shift  = {i_rem[REM_W-1:0], i_bit};
   assign w_diff   = {1'b0, w_shift} - {2'b00, i_dsr};
   assign o_qbit   = ~w_diff[REM_W+1];
   assign o_rem    = o_qbit ? w_diff[REM_W:0] : w_shift;
   assign w_unused = i_rem[REM_W];

endmodule

// File: rtl/case_4_sdiv_13s_10s_13_seq_1.sv
// ---------------------------------------------------------------------------
// case_4_sdiv_13s_10s_13_seq_1
// Sequential signed divider, 13-bit signed dividend / 10-bit signed divisor,
// C truncate-toward-zero semantics, one quotient bit per cycle.
//   clk, reset (async, active high), ce (clock enable)
//   start      : operand valid, sampled in IDLE
//   din0, din1 : dividend, divisor (signed)
//   busy       : operation in flight
//   done       : one-cycle (in ce=1 cycles) result-valid pulse
//   dout, rem  : quotient, remainder (signed), held until next result
//   div0       : zero-divisor flag, only with CASE_4_SDIV_DIV0_CHECK_EN
// Optional feature macro: CASE_4_SDIV_DIV0_CHECK_EN
// ---------------------------------------------------------------------------
module case_4_sdiv_13s_10s_13_seq_1
   import case_4_sdiv_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 15,
   parameter int din0_WIDTH = 13,
   parameter int din1_WIDTH = 10,
   parameter int dout_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
`ifdef CASE_4_SDIV_DIV0_CHECK_EN
   output logic [REM_W-1:0]      rem,
   output logic                  div0
`else
   output logic [REM_W-1:0]      rem
`endif
);

   localparam int unused_params = ID + NUM_STAGE;

   sdiv_state_t           r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [QUOT_W-1:0]     r_dvd;     // |dividend| shifting out, quotient shifting in
   logic [DIVISOR_W-1:0]  r_dsr;
   logic [REM_W:0]        r_rem;
   logic                  r_sign_q;
   logic                  r_sign_r;
   logic                  r_busy;
   logic                  r_done;
   logic [QUOT_W-1:0]     r_dout;
   logic [REM_W-1:0]      r_remo;
`ifdef CASE_4_SDIV_DIV0_CHECK_EN
   logic                  r_zero;
   logic                  r_div0;
`endif

   logic [REM_W:0]        w_rem_nxt;
   logic                  w_qbit;

   case_4_sdiv_13s_10s_13_seq_1_step u_step (
      .i_rem  (r_rem),
      .i_bit  (r_dvd[QUOT_W-1]),
      .i_dsr  (r_dsr),
      .o_rem  (w_rem_nxt),
      .o_qbit (w_qbit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_dvd    <= '0;
         r_dsr    <= '0;
         r_rem    <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dout   <= '0;
         r_remo   <= '0;
`ifdef CASE_4_SDIV_DIV0_CHECK_EN
         r_zero   <= 1'b0;
         r_div0   <= 1'b0;
`endif
      end else if (ce) begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_sign_q <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                  r_sign_r <= din0[DIVIDEND_W-1];
                  // |-4096| = 13'h1000 is still correct read as unsigned
                  r_dvd    <= din0[DIVIDEND_W-1] ? -din0 : din0;
                  r_dsr    <= din1[DIVISOR_W-1] ? -din1 : din1;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
`ifdef CASE_4_SDIV_DIV0_CHECK_EN
                  r_div0   <= 1'b0;
                  if (din1 == '0) begin
                     r_zero  <= 1'b1;
                     r_state <= FIX;
                  end else begin
                     r_zero  <= 1'b0;
                     r_state <= CALC;
                  end
`else
                  r_state  <= CALC;
`endif
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_dvd <= {r_dvd[QUOT_W-2:0], w_qbit};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(ITER - 1)) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_dout  <= r_sign_q ? -r_dvd : r_dvd;
               r_remo  <= r_sign_r ? -r_rem[REM_W-1:0] : r_rem[REM_W-1:0];
`ifdef CASE_4_SDIV_DIV0_CHECK_EN
               if (r_zero) begin
                  r_dout <= '0;
                  r_remo <= '0;
                  r_div0 <= 1'b1;
               end
`endif
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign dout = r_dout;
   assign rem  = r_remo;
`ifdef CASE_4_SDIV_DIV0_CHECK_EN
   assign div0 = r_div0;
`endif

endmodule

// File: doc/case_4_sdiv_13s_10s_13_seq_1.md
# case_4_sdiv_13s_10s_13_seq_1

Sequential signed divider: the inverse operator to the 13s × 10s → 13 multiplier used in the same datapath. It takes a 13-bit signed dividend and a 10-bit signed divisor and produces a 13-bit signed quotient and a 10-bit signed remainder, using C truncate-toward-zero semantics. It uses a radix-2 restoring loop, one quotient bit per cycle, behind a start/done handshake. It is instantiated by the scheduled datapath wherever a division is bound to a multi-cycle functional unit.

## Interface
- ID, 1, instance identifier (no functional effect)
- NUM_STAGE, 15, start-to-done latency in cycles (informational; must equal the implemented latency)
- din0_WIDTH, 13, dividend width
- din1_WIDTH, 10, divisor width
- dout_WIDTH, 13, quotient width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; when 0, all state, including outputs, holds
- start  in  1  operand valid; sampled in IDLE when ce=1
- din0  in  13  dividend, signed
- din1  in  10  divisor, signed
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle result-valid pulse (measured in ce=1 cycles)
- dout  out  13  quotient, signed
- rem  out  10  remainder, signed

## Operation
- States:
  - IDLE: accept start.
  - CALC: 13 iterations.
  - FIX: apply signs and register results.
  - Transitions: IDLE→CALC on start; CALC→FIX after iteration 13; FIX→IDLE.
- On accept:
  - Latch sign_q = din0[12]^din1[9] and sign_r = din0[12].
  - Latch |din0| as a 13-bit unsigned value (|−4096| = 4096 fits) and |din1| as a 10-bit unsigned value.
  - Clear the 11-bit partial remainder and the iteration counter.
- CALC, per iteration:
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial subtract |divisor| (11-bit compare).
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
- FIX:
  - dout = sign_q ? −q : q, truncated to 13 bits.
  - rem = sign_r ? −r : r, truncated to 10 bits.
  - |r| ≤ 511 always, so rem never overflows.
- Overflow: −4096 / −1 → dout = 13'h1000, rem = 0, wrapped and not flagged.
- Divisor zero (macro off): the loop runs normally, so q = 13'h1FFF.
  - dout = 13'h1FFF if dividend ≥ 0, 13'h0001 if negative.
  - rem = low 10 bits of |dividend|, with the dividend sign applied.
- start while busy is ignored; operands are not re-sampled.
- dout/rem hold their value until the next FIX.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, dout = 0, rem = 0.
- Reset asserted mid-operation aborts it: no done is issued and outputs return to 0.
- Latency (ce held at 1):
  - start sampled at edge E0.
  - busy is high from after E0 through the FIX cycle.
  - dout/rem update at edge E14; done is high for the cycle following E14.
  - Total: 15 cycles from start to done observed.
- Back-to-back: start may be asserted in the cycle done is high and is accepted at that edge. Throughput is one result per 15 cycles.
- ce = 0 stalls every register, including the done pulse. done stays high across a stall and is cleared after the next ce=1 edge.

## Configuration
- Macro: CASE_4_SDIV_DIV0_CHECK_EN.
- Defined:
  - Adds output div0 (1 bit, reset 0).
  - A zero divisor at accept skips CALC: IDLE→FIX, so done arrives 2 cycles after start.
  - Result: dout = 0, rem = 0, div0 = 1.
  - div0 is valid with done and is cleared on the next accepted start.
- Undefined:
  - No div0 port.
  - Zero-divisor behaviour is as described in Operation.
  - Latency is always 15 cycles.

## Structure
- Package case_4_sdiv_pkg contains:
  - Width constants: DIVIDEND_W = 13, DIVISOR_W = 10, QUOT_W = 13, REM_W = 10, ITER = 13.
  - State enum sdiv_state_t {IDLE, CALC, FIX}.
  - Counter width $clog2(ITER+1).
- One combinational sub-module, case_4_sdiv_13s_10s_13_seq_1_step: shift-in, trial subtract, select. Inputs: partial remainder, dividend bit, |divisor|. Outputs: next remainder and quotient bit.

## Test plan
- 100 / 7, ce = 1 → after 15 cycles: done = 1, dout = 14 (13'h000E), rem = 2.
- −100 / 7 → dout = 13'h1FF2 (−14), rem = 10'h3FE (−2). Then 100 / −7 → dout = −14, rem = 2.
- −4096 / −1 → dout = 13'h1000, rem = 0. Then 4095 / −512 → dout = −7 (13'h1FF9), rem = 511.
- 1000 / 0:
  - Macro off: done at 15, dout = 13'h1FFF, rem = 10'h3E8.
  - Macro on: done at 2, dout = 0, div0 = 1.
- Back-to-back: 50 / 5 then −9 / 2, with the second start asserted during the first done. Expect dout = 10, then −4 with rem = −1, with done pulses exactly 15 cycles apart.
- Stall and reset:
  - ce low for 5 cycles mid-CALC → done arrives at 20 with the correct result.
  - reset pulsed at cycle 7 → busy = 0, done never fires, dout = 0.
  - A new start afterwards completes normally.
